// File: rtl/bcd_7seg.sv
// Registered BCD-to-seven-segment decoder for one display digit.
// Lamp test overrides blanking, which overrides the decoded digit. Polarity inversion is
// applied to the final registered pattern, so reset, lamp test and blank all follow it.
module bcd_7seg #(
  parameter bit ACTIVE_LOW = 1'b0,  // 1: invert every segment bit (common anode)
  parameter bit HEX_EN     = 1'b0   // 1: codes 10-15 show A,b,C,d,E,F instead of erroring
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] bcd_i,
  input  logic       lamp_test_i,
  input  logic       blank_i,
  output logic [6:0] seg_o,
  output logic       err_o
);

  localparam logic [6:0] PolMask = {7{ACTIVE_LOW}};

  // Returns {invalid, pattern} with the pattern in active-high {a..g} form.
  function automatic logic [7:0] decode_digit(input logic [3:0] code);
    logic [7:0] res;
    case (code)
      4'd0:    res = {1'b0, 7'h7E};
      4'd1:    res = {1'b0, 7'h30};
      4'd2:    res = {1'b0, 7'h6D};
      4'd3:    res = {1'b0, 7'h79};
      4'd4:    res = {1'b0, 7'h33};
      4'd5:    res = {1'b0, 7'h5B};
      4'd6:    res = {1'b0, 7'h5F};
      4'd7:    res = {1'b0, 7'h70};
      4'd8:    res = {1'b0, 7'h7F};
      4'd9:    res = {1'b0, 7'h7B};
      4'd10:   res = HEX_EN ? {1'b0, 7'h77} : {1'b1, 7'h00};
      4'd11:   res = HEX_EN ? {1'b0, 7'h1F} : {1'b1, 7'h00};
      4'd12:   res = HEX_EN ? {1'b0, 7'h4E} : {1'b1, 7'h00};
      4'd13:   res = HEX_EN ? {1'b0, 7'h3D} : {1'b1, 7'h00};
      4'd14:   res = HEX_EN ? {1'b0, 7'h4F} : {1'b1, 7'h00};
      4'd15:   res = HEX_EN ? {1'b0, 7'h47} : {1'b1, 7'h00};
      // Unreachable for 2-state codes; matches the invalid-code result.
      default: res = {1'b1, 7'h00};
    endcase
    return res;
  endfunction

  logic [6:0] seg_d, seg_q;
  logic       err_d, err_q;
  logic [6:0] pattern;
  logic [7:0] dec;

  // Priority mux: lamp test > blank > decode, then output polarity.
  always_comb begin
    dec     = decode_digit(bcd_i);
    pattern = 7'h00;
    err_d   = 1'b0;
    if (lamp_test_i) begin
      pattern = 7'h7F;
    end else if (blank_i) begin
      pattern = 7'h00;
    end else begin
      pattern = dec[6:0];
      err_d   = dec[7];
    end
    seg_d = pattern ^ PolMask;
  end

  // Output register; reset drives every segment dark in the selected polarity.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_q <= PolMask;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      err_q <= err_d;
    end
  end

  assign seg_o = seg_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_bcd_7seg.sv
// Self-checking bench for bcd_7seg: all four ACTIVE_LOW/HEX_EN variants driven in parallel
// and compared against a table-based reference model.
`timescale 1ns/1ps
module tb_bcd_7seg;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] bcd_i = 4'd8;
  logic       lamp_test_i = 1'b0;
  logic       blank_i = 1'b0;
  logic [6:0] seg [4];
  logic       err [4];

  int n_vec = 0;
  int n_err = 0;

  // Variant v: ACTIVE_LOW = v[0], HEX_EN = v[1].
  for (genvar g = 0; g < 4; g++) begin : g_dut
    bcd_7seg #(
      .ACTIVE_LOW((g % 2) == 1),
      .HEX_EN    ((g / 2) == 1)
    ) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bcd_i      (bcd_i),
      .lamp_test_i(lamp_test_i),
      .blank_i    (blank_i),
      .seg_o      (seg[g]),
      .err_o      (err[g])
    );
  end

  always #10 clk_i = ~clk_i;

  logic [6:0] dig_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] hex_tab [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference: returns {err, seg} for the given inputs and variant.
  function automatic logic [7:0] model(input int code, input bit lt, input bit bl,
                                       input bit al, input bit hex);
    logic [6:0] pat;
    logic       e;
    e = 1'b0;
    if (lt)             pat = 7'h7F;
    else if (bl)        pat = 7'h00;
    else if (code < 10) pat = dig_tab[code];
    else if (hex)       pat = hex_tab[code - 10];
    else begin
      pat = 7'h00;
      e   = 1'b1;
    end
    if (al) pat = ~pat;
    return {e, pat};
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp [4]);
    for (int v = 0; v < 4; v++) begin
      check_val($sformatf("%s v%0d seg", tag, v), {1'b0, seg[v]}, {1'b0, exp[v][6:0]});
      check_val($sformatf("%s v%0d err", tag, v), {7'b0, err[v]}, {7'b0, exp[v][7]});
    end
  endtask

  task automatic check_dark(input string tag);
    logic [7:0] exp [4];
    for (int v = 0; v < 4; v++) exp[v] = {1'b0, {7{v[0]}}};
    check_all(tag, exp);
  endtask

  // Apply inputs at the falling edge, check after the rising edge, then scramble the
  // inputs mid-cycle and confirm the outputs hold.
  task automatic step(input string tag, input int code, input bit lt, input bit bl);
    logic [7:0] exp [4];
    @(negedge clk_i);
    bcd_i       = 4'(code);
    lamp_test_i = lt;
    blank_i     = bl;
    for (int v = 0; v < 4; v++) exp[v] = model(code, lt, bl, v[0], v[1]);
    @(posedge clk_i);
    #2;
    check_all(tag, exp);
    #3;
    bcd_i       = 4'($urandom);
    lamp_test_i = 1'($urandom);
    blank_i     = 1'($urandom);
    #2;
    check_all({tag, " hold"}, exp);
  endtask

  initial begin
    // Reset held with clocks running and bcd=8.
    repeat (3) @(posedge clk_i);
    #2;
    check_dark("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_reset", 8, 0, 0);

    for (int i = 0; i < 10; i++) step($sformatf("sweep%0d", i), i, 0, 0);
    step("inv10", 10, 0, 0);
    step("inv15", 15, 0, 0);
    step("after_inv", 3, 0, 0);
    step("blank2", 2, 0, 1);
    step("lt_blank2", 2, 1, 1);
    step("lt_blank12", 12, 1, 1);
    step("blank12", 12, 0, 1);
    for (int i = 10; i < 16; i++) step($sformatf("hex%0d", i), i, 0, 0);

    // Asynchronous reset between edges while showing 6.
    step("pre_async", 6, 0, 0);
    rst_ni = 1'b0;
    #2;
    check_dark("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("after_async", 4, 0, 0);

    for (int i = 0; i < 200; i++) begin
      step($sformatf("rand%0d", i), int'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_7seg.md
Name: bcd_7seg

Overview:
- Registered BCD-to-seven-segment decoder for a single display digit.
- Converts a 4-bit BCD code into seven segment drive lines, a-g, plus an invalid-code flag.
- Supports lamp test, blanking, selectable output polarity and optional hex decoding.
- Sits between digit-select/counter logic and the display pin drivers.

Parameters:
- ACTIVE_LOW, 0: 0 = segment lit when its bit is 1 (common cathode); 1 = every seg bit inverted at the output (common anode).
- HEX_EN, 0: 0 = codes 10-15 blank the display and assert err; 1 = codes 10-15 display A,b,C,d,E,F with err=0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd  input  4  digit code to display.
- lamp_test  input  1  forces all seven segments lit.
- blank  input  1  forces all segments dark.
- seg  output  7  segment drive, bit order {a,b,c,d,e,f,g}: seg[6]=a, seg[0]=g.
- err  output  1  registered flag: bcd was outside 0-9 with HEX_EN=0.

Behaviour:
- One clock, rising edge. rst_n is asynchronous assert, synchronous deassert at the system level.
- While rst_n=0, outputs are forced immediately, independent of clk:
  - seg = all segments dark: 7'h00 if ACTIVE_LOW=0, 7'h7F if ACTIVE_LOW=1.
  - err = 0.
- Latency: exactly one clock. Inputs sampled on rising edge N appear on seg/err after edge N. No combinational input-to-output path.
- Priority per cycle, highest first: lamp_test > blank > decode.
  - lamp_test=1: pattern 7'h7F; err=0.
  - blank=1 (lamp_test=0): pattern 7'h00; err=0.
  - Otherwise, decode pattern in active-high form {a..g}:
    - 0=7E, 1=30, 2=6D, 3=79, 4=33
    - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - Codes 10-15:
    - HEX_EN=0: pattern 7'h00 and err=1.
    - HEX_EN=1: patterns A=77, b=1F, C=4E, d=3D, E=4F, F=47; err=0.
- Output stage: seg register = pattern XOR {7{ACTIVE_LOW}}. Polarity inversion is applied after the priority mux, so it also covers lamp test, blank and reset.
- err is cleared by any valid code, lamp_test or blank. It is never sticky.
- Input changes between edges have no effect on the outputs. Only the value present at the edge is used.
- Reset mid-operation: outputs go dark/0 asynchronously. The first edge after rst_n rises loads the current inputs.
- Unknown/X on bcd need not be handled. Synthesis uses a full case with an explicit default equal to the invalid-code result.
- Implementation:
  - Decode table as a combinational function.
  - Priority mux.
  - Output register with async reset.
  - Parameter-generated polarity and hex branches.

Test Plan:
- Reset: hold rst_n=0 with bcd=8 and clocks running -> seg=00, err=0. Release, clock once -> seg=7F.
- Sweep bcd 0..9, one per cycle (ACTIVE_LOW=0, HEX_EN=0) -> one cycle later seg = 7E,30,6D,79,33,5B,5F,70,7F,7B; err=0 throughout.
- Invalid codes: bcd=10 and bcd=15 -> seg=00, err=1. Then bcd=3 -> seg=79, err=0.
- Priority: bcd=2 with blank=1 -> seg=00. Add lamp_test=1 -> seg=7F, err=0. Same with bcd=12 -> err stays 0.
- Parameter variants:
  - ACTIVE_LOW=1: bcd=0 -> seg=01; reset -> seg=7F.
  - HEX_EN=1: bcd 10..15 -> 77,1F,4E,3D,4F,47 with err=0.
- Async reset mid-stream: drop rst_n between clock edges while seg=5F -> seg=00 immediately, before the next edge.
